// File: rtl/dm_defs_pkg.sv
// Shared definitions for the data-memory port arbiter: access-mode codes and
// the read-return owner encoding.
package dm_defs;

   typedef enum logic [2:0] {
      BY_WORD   = 3'd0,
      BY_HALF   = 3'd1,
      BY_HALF_U = 3'd2,
      BY_BYTE   = 3'd3,
      BY_BYTE_U = 3'd4
   } dm_mode_e;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_C    = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

endpackage

// File: rtl/dm_starve_timer.sv
// Saturating count of consecutive denied request cycles; at_limit flags that
// the requester must be forced to win this cycle.
module dm_starve_timer #(
   parameter int LIMIT = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic req,
   input  logic gnt,
   output logic at_limit
);

   logic [7:0] count;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (!req || gnt) begin
         count <= '0;
      end else if (count != 8'(LIMIT)) begin
         count <= count + 8'd1;
      end
   end

   assign at_limit = (count == 8'(LIMIT));

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port (C = CPU, D = debug/DMA) arbiter in front of a single-port data
// memory. Optional grant/conflict statistics when DM_ARB_STATS_EN is defined.
module dm_port_arbiter
   import dm_defs::*;
#(
   parameter int ADDR_W       = 15,
   parameter int DEPTH        = 4096,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [31:0]       c_wdata,
   input  logic [2:0]        c_mode,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [31:0]       c_rdata,
   output logic              c_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic [2:0]        d_mode,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_err,
`ifdef DM_ARB_STATS_EN
   input  logic              stat_clr,
   output logic [31:0]       stat_c_cnt,
   output logic [31:0]       stat_d_cnt,
   output logic [31:0]       stat_conf_cnt,
`endif
   output logic              m_we,
   output logic [ADDR_W-1:0] m_addr,
   output logic [31:0]       m_din,
   output logic [2:0]        m_mode,
   input  logic [31:0]       m_dout
);

   logic   at_limit;
   logic   c_oob, d_oob;
   logic   c_err_q, d_err_q;
   owner_e state_q, state_d;

   assign c_oob = (c_addr >= ADDR_W'(DEPTH));
   assign d_oob = (d_addr >= ADDR_W'(DEPTH));

   // Grants are suppressed during reset so nothing reaches memory while rst is high.
   assign d_gnt = !rst && d_req && (at_limit || !c_req);
   assign c_gnt = !rst && c_req && !d_gnt;

   dm_starve_timer #(.LIMIT(STARVE_LIMIT)) u_starve (
      .clk      (clk),
      .rst      (rst),
      .req      (d_req),
      .gnt      (d_gnt),
      .at_limit (at_limit)
   );

   always_comb begin
      // NOTE: every combinational output gets a default first so no latch is inferred.
      m_we   = 1'b0;
      m_addr = '0;
      m_din  = '0;
      m_mode = '0;
      if (c_gnt) begin
         m_we   = c_we && !c_oob;
         m_addr = c_addr;
         m_din  = c_wdata;
         m_mode = c_mode;
      end else if (d_gnt) begin
         m_we   = d_we && !d_oob;
         m_addr = d_addr;
         m_din  = d_wdata;
         m_mode = d_mode;
      end
   end

   always_comb begin
      state_d = OWN_NONE;
      if (c_gnt && !c_we)      state_d = OWN_C;
      else if (d_gnt && !d_we) state_d = OWN_D;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= OWN_NONE;
         c_err_q <= 1'b0;
         d_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         c_err_q <= c_gnt && c_oob;
         d_err_q <= d_gnt && d_oob;
      end
   end

   // Out-of-range reads still return a beat, but with zeroed data.
   assign c_rvalid = (state_q == OWN_C);
   assign d_rvalid = (state_q == OWN_D);
   assign c_rdata  = (c_rvalid && !c_err_q) ? m_dout : 32'd0;
   assign d_rdata  = (d_rvalid && !d_err_q) ? m_dout : 32'd0;
   assign c_err    = c_err_q;
   assign d_err    = d_err_q;

`ifdef DM_ARB_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_c_cnt    <= '0;
         stat_d_cnt    <= '0;
         stat_conf_cnt <= '0;
      end else if (stat_clr) begin
         stat_c_cnt    <= '0;
         stat_d_cnt    <= '0;
         stat_conf_cnt <= '0;
      end else begin
         if (c_gnt)          stat_c_cnt    <= stat_c_cnt + 32'd1;
         if (d_gnt)          stat_d_cnt    <= stat_d_cnt + 32'd1;
         if (c_req && d_req) stat_conf_cnt <= stat_conf_cnt + 32'd1;
      end
   end
`endif

endmodule
